alarm_rtc: RTL

ALARM_RTC -- requirements
Module: alarm_rtc

---
 rtl/alarm_rtc_pkg.sv | 31 +++
 rtl/alarm_rtc_time_chain.sv | 30 +++
 rtl/alarm_rtc.sv | 97 +++++++++
 3 files changed

// File: rtl/alarm_rtc_pkg.sv
// alarm_rtc_pkg: register map, control/status bit positions, time limits and
// time helpers shared by the alarm RTC top and its time chain.
package alarm_rtc_pkg;
  typedef enum logic [2:0] {
    A_STATUS   = 3'd0,
    A_CONTROL  = 3'd1,
    A_TIME_HM  = 3'd2,
    A_TIME_S   = 3'd3,
    A_ALARM_HM = 3'd4,
    A_SNOOZE   = 3'd5
  } reg_addr_e;
  localparam int C_IRQ_EN   = 0;
  localparam int C_ALARM_EN = 1;
  localparam int C_RUN      = 2;
  localparam int C_SNOOZE   = 3;
  localparam int S_FLAG     = 0;
  localparam int S_RUNNING  = 1;
  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] SNOOZE_MIN_RST = 6'd5;
  function automatic logic hm_ok(input logic [15:0] d);
    return d[12:8] <= MAX_HOUR && d[5:0] <= MAX_MIN;
  endfunction
  // hh:mm + d minutes, carrying into hours and wrapping at midnight
  function automatic logic [10:0] hm_add(input logic [4:0] h, input logic [5:0] m, input logic [5:0] d);
    logic [6:0] s;
    s = {1'b0, m} + {1'b0, d};
    return s > {1'b0, MAX_MIN} ? {h == MAX_HOUR ? 5'd0 : h + 5'd1, 6'(s - 7'd60)} : {h, s[5:0]};
  endfunction
endpackage

// File: rtl/alarm_rtc_time_chain.sv
// alarm_rtc_time_chain: seconds/minutes/hours counters; loads take priority
// over the one-second advance.
module alarm_rtc_time_chain
  import alarm_rtc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adv,
  input  logic       ld_hm,
  input  logic       ld_s,
  input  logic [4:0] ld_hours,
  input  logic [5:0] ld_minutes,
  input  logic [5:0] ld_seconds,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds
);
  logic s_wrap, m_wrap;
  assign s_wrap = seconds == MAX_SEC;
  assign m_wrap = minutes == MAX_MIN;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {hours, minutes, seconds} <= '0;
    else if (ld_hm) {hours, minutes, seconds} <= {ld_hours, ld_minutes, 6'd0};
    else if (ld_s) seconds <= ld_seconds;
    else if (adv) begin
      seconds <= s_wrap ? 6'd0 : seconds + 6'd1;
      if (s_wrap) minutes <= m_wrap ? 6'd0 : minutes + 6'd1;
      if (s_wrap && m_wrap) hours <= hours == MAX_HOUR ? 5'd0 : hours + 5'd1;
    end
endmodule

// File: rtl/alarm_rtc.sv
// alarm_rtc: tick-driven real-time clock with alarm interrupt and register slave.
// Define ALARM_RTC_SNOOZE_EN to build in the snooze feature.
module alarm_rtc
  import alarm_rtc_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);
  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
  logic wr, wr_hm, wr_s, wr_ctl, wr_st, sec_adv, adv_d, flag, al_hit, sn_hit, snz;
  logic [2:0] ctrl;
  logic [15:0] cnt, rd;
  logic [4:0] hours, al_h;
  logic [5:0] minutes, seconds, al_m;
  logic unused_wd;
  assign wr = chipselect & ~write_n;
  assign wr_hm = wr && address == A_TIME_HM && hm_ok(writedata);
  assign wr_s = wr && address == A_TIME_S && writedata[5:0] <= MAX_SEC;
  assign wr_ctl = wr && address == A_CONTROL;
  assign wr_st = wr && address == A_STATUS;
  // a valid time write drops any advance landing in the same cycle
  assign sec_adv = ctrl[C_RUN] && tick && cnt == DIV_LAST && !(wr_hm || wr_s);
  assign al_hit = adv_d && seconds == 6'd0 && ctrl[C_ALARM_EN] && {hours, minutes} == {al_h, al_m};
  assign irq = flag & ctrl[C_IRQ_EN];
  assign unused_wd = ^{writedata[15:13], writedata[7:6]};
  alarm_rtc_time_chain u_chain (
    .clk       (clk),
    .reset_n   (reset_n),
    .adv       (sec_adv),
    .ld_hm     (wr_hm),
    .ld_s      (wr_s),
    .ld_hours  (writedata[12:8]),
    .ld_minutes(writedata[5:0]),
    .ld_seconds(writedata[5:0]),
    .hours     (hours),
    .minutes   (minutes),
    .seconds   (seconds)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      ctrl <= '0;
      {al_h, al_m} <= '0;
      flag <= 1'b0;
      adv_d <= 1'b0;
    end else begin
      cnt <= (wr_hm || wr_s) ? 16'd0 : !(ctrl[C_RUN] && tick) ? cnt : cnt == DIV_LAST ? 16'd0 : cnt + 16'd1;
      adv_d <= sec_adv;
      flag <= al_hit | sn_hit | (flag & ~(wr_st | snz));
      if (wr_ctl) ctrl <= writedata[2:0];
      if (wr && address == A_ALARM_HM && hm_ok(writedata)) {al_h, al_m} <= {writedata[12:8], writedata[5:0]};
    end
`ifdef ALARM_RTC_SNOOZE_EN
  logic [5:0] sn_min;
  logic [10:0] sn_tgt;
  logic sn_act;
  assign snz = wr_ctl && writedata[C_SNOOZE] && flag;
  assign sn_hit = adv_d && seconds == 6'd0 && sn_act && {hours, minutes} == sn_tgt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sn_min <= SNOOZE_MIN_RST;
      sn_tgt <= '0;
      sn_act <= 1'b0;
    end else begin
      if (wr && address == A_SNOOZE && writedata[5:0] <= MAX_MIN) sn_min <= writedata[5:0];
      if (snz) sn_tgt <= hm_add(hours, minutes, sn_min);
      sn_act <= snz | (sn_act & ~sn_hit);
    end
`else
  assign snz = 1'b0;
  assign sn_hit = 1'b0;
`endif
  always_comb
    case (address)
      A_STATUS:   rd = {14'd0, ctrl[C_RUN], flag};
      A_CONTROL:  rd = {13'd0, ctrl};
      A_TIME_HM:  rd = {3'd0, hours, 2'd0, minutes};
      A_TIME_S:   rd = {10'd0, seconds};
      A_ALARM_HM: rd = {3'd0, al_h, 2'd0, al_m};
`ifdef ALARM_RTC_SNOOZE_EN
      A_SNOOZE:   rd = {10'd0, sn_min};
`endif
      default:    rd = 16'd0;
    endcase
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else readdata <= rd;
endmodule
